clk_time_set_ctrl: RTL and testbench

- Button-driven time-set sequencer for the 12-hour clock datapath (digital_clk_12hr_ms).
- Captures the running time into shadow registers and lets the user edit hour, minute and second fields in turn.
- Drives the datapath's Timeset/Hourset/Minset/Secset load interface for a fixed number of cycles to commit the new time.
- Sits between debounced front-panel buttons and the clock datapath, one clock domain.

---
 rtl/clk_time_set_ctrl.sv | 177 +++++++++++++++++
 tb/tb_clk_time_set_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/clk_time_set_ctrl.sv
// rtl/clk_time_set_ctrl.sv - button-driven time-set sequencer for the 12-hour clock datapath
module clk_time_set_ctrl #(
  parameter int LOAD_CYCLES = 2,
  parameter int REPEAT_DLY  = 500,
  parameter int REPEAT_RATE = 100,
  parameter int TIMEOUT     = 10000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       mode_i,
  input  logic       inc_i,
  input  logic       cancel_i,
  input  logic [4:0] hour_i,
  input  logic [5:0] min_i,
  input  logic [5:0] sec_i,
  output logic       Timeset,
  output logic [4:0] Hourset,
  output logic [5:0] Minset,
  output logic [5:0] Secset,
  output logic       editing_o,
  output logic [1:0] field_o
);

  localparam int RW = $clog2(REPEAT_DLY + REPEAT_RATE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int LW = $clog2(LOAD_CYCLES + 1);

  typedef enum logic [2:0] {
    S_RUN      = 3'd0,
    S_EDIT_HR  = 3'd1,
    S_EDIT_MIN = 3'd2,
    S_EDIT_SEC = 3'd3,
    S_LOAD     = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          mode_q, inc_q, cancel_q;
  logic [RW-1:0] rpt_q, rpt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [LW-1:0] ld_q, ld_d;
  logic          timeset_q, timeset_d;
  logic [4:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic          editing_q, editing_d;
  logic [1:0]    field_q, field_d;

  logic mode_ev, inc_ev, cancel_ev;
  logic in_edit, rpt_fire, do_inc, tmo_hit;

  function automatic logic [4:0] hour_next(input logic [4:0] h);
    return (h >= 5'd12) ? 5'd1 : h + 5'd1;
  endfunction

  function automatic logic [5:0] sixty_next(input logic [5:0] v);
    return (v >= 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  always_comb begin
    mode_ev   = mode_i & ~mode_q;
    inc_ev    = inc_i & ~inc_q;
    cancel_ev = cancel_i & ~cancel_q;
    in_edit   = (state_q == S_EDIT_HR) || (state_q == S_EDIT_MIN) || (state_q == S_EDIT_SEC);

    // Repeat counter tracks cycles inc_i has been high; it folds back after each periodic step.
    rpt_fire = in_edit && inc_i && !inc_ev &&
               ((rpt_q == RW'(REPEAT_DLY)) || (rpt_q == RW'(REPEAT_DLY + REPEAT_RATE)));
    if (in_edit && inc_i)
      rpt_d = (rpt_q == RW'(REPEAT_DLY + REPEAT_RATE)) ? RW'(REPEAT_DLY + 1) : rpt_q + RW'(1);
    else
      rpt_d = '0;

    do_inc  = inc_ev | rpt_fire;
    tmo_hit = (tmo_q == TW'(TIMEOUT - 1));
    tmo_d   = in_edit ? tmo_q + TW'(1) : '0;

    state_d = state_q;
    ld_d    = ld_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;

    case (state_q)
      S_RUN: begin
        if (mode_ev) begin
          hour_d  = ((hour_i == 5'd0) || (hour_i > 5'd12)) ? 5'd12 : hour_i;
          min_d   = (min_i > 6'd59) ? 6'd0 : min_i;
          sec_d   = (sec_i > 6'd59) ? 6'd0 : sec_i;
          state_d = S_EDIT_HR;
        end
      end
      S_EDIT_HR, S_EDIT_MIN, S_EDIT_SEC: begin
        if (cancel_ev) begin
          state_d = S_RUN;
        end else if (mode_ev) begin
          ld_d = '0;
          case (state_q)
            S_EDIT_HR:  state_d = S_EDIT_MIN;
            S_EDIT_MIN: state_d = S_EDIT_SEC;
            default:    state_d = S_LOAD;
          endcase
        end else if (do_inc) begin
          tmo_d = '0;
          case (state_q)
            S_EDIT_HR:  hour_d = hour_next(hour_q);
            S_EDIT_MIN: min_d  = sixty_next(min_q);
            default:    sec_d  = sixty_next(sec_q);
          endcase
        end else if (tmo_hit) begin
          state_d = S_RUN;
        end
      end
      S_LOAD: begin
        if (ld_q == LW'(LOAD_CYCLES - 1))
          state_d = S_RUN;
        else
          ld_d = ld_q + LW'(1);
      end
      default: state_d = S_RUN;
    endcase

    if (state_d != state_q) begin
      rpt_d = '0;
      tmo_d = '0;
    end

    timeset_d = (state_d == S_LOAD);
    editing_d = (state_d == S_EDIT_HR) || (state_d == S_EDIT_MIN) || (state_d == S_EDIT_SEC);
    case (state_d)
      S_EDIT_HR:  field_d = 2'b01;
      S_EDIT_MIN: field_d = 2'b10;
      S_EDIT_SEC: field_d = 2'b11;
      default:    field_d = 2'b00;
    endcase
  end

  // Button copies reset high so a button held through reset release yields no edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_RUN;
      mode_q    <= 1'b1;
      inc_q     <= 1'b1;
      cancel_q  <= 1'b1;
      rpt_q     <= '0;
      tmo_q     <= '0;
      ld_q      <= '0;
      timeset_q <= 1'b0;
      hour_q    <= 5'd12;
      min_q     <= 6'd0;
      sec_q     <= 6'd0;
      editing_q <= 1'b0;
      field_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_i;
      inc_q     <= inc_i;
      cancel_q  <= cancel_i;
      rpt_q     <= rpt_d;
      tmo_q     <= tmo_d;
      ld_q      <= ld_d;
      timeset_q <= timeset_d;
      hour_q    <= hour_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      editing_q <= editing_d;
      field_q   <= field_d;
    end
  end

  assign Timeset   = timeset_q;
  assign Hourset   = hour_q;
  assign Minset    = min_q;
  assign Secset    = sec_q;
  assign editing_o = editing_q;
  assign field_o   = field_q;

endmodule

// File: tb/tb_clk_time_set_ctrl.sv
// tb/tb_clk_time_set_ctrl.sv - scoreboard bench for clk_time_set_ctrl
module tb_clk_time_set_ctrl;

  localparam int DLY  = 5;
  localparam int RATE = 2;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       mode_i, inc_i, cancel_i;
  logic [4:0] hour_i;
  logic [5:0] min_i, sec_i;
  logic       Timeset;
  logic [4:0] Hourset;
  logic [5:0] Minset, Secset;
  logic       editing_o;
  logic [1:0] field_o;

  int n_checks = 0;
  int n_err    = 0;

  logic [20:0] exp_q[$];
  string       tag_q[$];

  always #5 clk_i = ~clk_i;

  clk_time_set_ctrl #(
    .LOAD_CYCLES(2),
    .REPEAT_DLY (DLY),
    .REPEAT_RATE(RATE),
    .TIMEOUT    (20)
  ) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .mode_i   (mode_i),
    .inc_i    (inc_i),
    .cancel_i (cancel_i),
    .hour_i   (hour_i),
    .min_i    (min_i),
    .sec_i    (sec_i),
    .Timeset  (Timeset),
    .Hourset  (Hourset),
    .Minset   (Minset),
    .Secset   (Secset),
    .editing_o(editing_o),
    .field_o  (field_o)
  );

  function automatic logic [20:0] pk(input logic ts, input logic [4:0] hr, input logic [5:0] mn,
                                     input logic [5:0] sc, input logic ed, input logic [1:0] fld);
    return {ts, hr, mn, sc, ed, fld};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic compare_head();
    logic [20:0] e;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check({t, ".Timeset"}, 32'(Timeset),   32'(e[20]));
    check({t, ".Hourset"}, 32'(Hourset),   32'(e[19:15]));
    check({t, ".Minset"},  32'(Minset),    32'(e[14:9]));
    check({t, ".Secset"},  32'(Secset),    32'(e[8:3]));
    check({t, ".editing"}, 32'(editing_o), 32'(e[2]));
    check({t, ".field"},   32'(field_o),   32'(e[1:0]));
  endtask

  task automatic step(input logic m, input logic i, input logic c, input string t, input logic [20:0] e);
    mode_i   = m;
    inc_i    = i;
    cancel_i = c;
    exp_q.push_back(e);
    tag_q.push_back(t);
    tick();
    compare_head();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int mn;
    reset_i = 1'b1; mode_i = 1'b0; inc_i = 1'b0; cancel_i = 1'b0;
    hour_i = 5'd3; min_i = 6'd15; sec_i = 6'd7;
    tick(); tick();
    exp_q.push_back(pk(0, 12, 0, 0, 0, 2'b00)); tag_q.push_back("reset");
    compare_head();
    reset_i = 1'b0;
    step(0, 0, 0, "idle",    pk(0, 12, 0, 0, 0, 2'b00));
    step(1, 0, 0, "capture", pk(0, 3, 15, 7, 1, 2'b01));
    step(0, 0, 0, "cap_hold", pk(0, 3, 15, 7, 1, 2'b01));
    step(0, 0, 1, "cancel",  pk(0, 3, 15, 7, 0, 2'b00));
    step(0, 0, 0, "run_idle", pk(0, 3, 15, 7, 0, 2'b00));

    // full edit with wraps on every field, then commit
    hour_i = 5'd11; min_i = 6'd59; sec_i = 6'd59;
    step(1, 0, 0, "w_cap",   pk(0, 11, 59, 59, 1, 2'b01));
    step(0, 0, 0, "w_gap",   pk(0, 11, 59, 59, 1, 2'b01));
    step(0, 1, 0, "w_inc_h", pk(0, 12, 59, 59, 1, 2'b01));
    step(0, 0, 0, "w_gap",   pk(0, 12, 59, 59, 1, 2'b01));
    step(1, 0, 0, "w_to_m",  pk(0, 12, 59, 59, 1, 2'b10));
    step(0, 0, 0, "w_gap",   pk(0, 12, 59, 59, 1, 2'b10));
    step(0, 1, 0, "w_inc_m", pk(0, 12, 0, 59, 1, 2'b10));
    step(0, 0, 0, "w_gap",   pk(0, 12, 0, 59, 1, 2'b10));
    step(1, 0, 0, "w_to_s",  pk(0, 12, 0, 59, 1, 2'b11));
    step(0, 0, 0, "w_gap",   pk(0, 12, 0, 59, 1, 2'b11));
    step(0, 1, 0, "w_inc_s", pk(0, 12, 0, 0, 1, 2'b11));
    step(0, 0, 0, "w_gap",   pk(0, 12, 0, 0, 1, 2'b11));
    step(1, 0, 0, "load1",   pk(1, 12, 0, 0, 0, 2'b00));
    step(0, 0, 0, "load2",   pk(1, 12, 0, 0, 0, 2'b00));
    step(0, 0, 0, "post1",   pk(0, 12, 0, 0, 0, 2'b00));
    step(0, 0, 0, "post2",   pk(0, 12, 0, 0, 0, 2'b00));

    // hour 12 -> 1, minute 59 -> 0 with hour untouched
    hour_i = 5'd12; min_i = 6'd59; sec_i = 6'd0;
    step(1, 0, 0, "h12_cap", pk(0, 12, 59, 0, 1, 2'b01));
    step(0, 0, 0, "h12_gap", pk(0, 12, 59, 0, 1, 2'b01));
    step(0, 1, 0, "h12_inc", pk(0, 1, 59, 0, 1, 2'b01));
    step(0, 0, 0, "h12_gap", pk(0, 1, 59, 0, 1, 2'b01));
    step(1, 0, 0, "m59_to",  pk(0, 1, 59, 0, 1, 2'b10));
    step(0, 0, 0, "m59_gap", pk(0, 1, 59, 0, 1, 2'b10));
    step(0, 1, 0, "m59_inc", pk(0, 1, 0, 0, 1, 2'b10));
    step(0, 0, 1, "m59_can", pk(0, 1, 0, 0, 0, 2'b00));
    step(0, 0, 0, "m59_run", pk(0, 1, 0, 0, 0, 2'b00));

    // clamping of out-of-range captures
    hour_i = 5'd0; min_i = 6'd60; sec_i = 6'd63;
    step(1, 0, 0, "clamp0",  pk(0, 12, 0, 0, 1, 2'b01));
    step(0, 0, 1, "clamp_c", pk(0, 12, 0, 0, 0, 2'b00));
    hour_i = 5'd13; min_i = 6'd1; sec_i = 6'd2;
    step(0, 0, 0, "clamp_g", pk(0, 12, 0, 0, 0, 2'b00));
    step(1, 0, 0, "clamp13", pk(0, 12, 1, 2, 1, 2'b01));
    step(0, 0, 1, "clamp_c", pk(0, 12, 1, 2, 0, 2'b00));
    step(0, 0, 0, "clamp_g", pk(0, 12, 1, 2, 0, 2'b00));

    // auto-repeat in EDIT_MIN starting at 10
    hour_i = 5'd5; min_i = 6'd10; sec_i = 6'd30;
    step(1, 0, 0, "r_cap",  pk(0, 5, 10, 30, 1, 2'b01));
    step(0, 0, 0, "r_gap",  pk(0, 5, 10, 30, 1, 2'b01));
    step(1, 0, 0, "r_to_m", pk(0, 5, 10, 30, 1, 2'b10));
    step(0, 0, 0, "r_gap",  pk(0, 5, 10, 30, 1, 2'b10));
    mn = 10;
    for (int k = 0; k < 12; k++) begin
      if (k == 0 || k == DLY || (k > DLY && ((k - DLY) % RATE) == 0)) mn++;
      step(0, 1, 0, $sformatf("rpt_k%0d", k), pk(0, 5, mn[5:0], 30, 1, 2'b10));
    end
    for (int k = 0; k < 3; k++)
      step(0, 0, 0, "rpt_rel", pk(0, 5, 15, 30, 1, 2'b10));
    step(1, 0, 1, "cxl_mode", pk(0, 5, 15, 30, 0, 2'b00));
    step(0, 0, 0, "cxl_post", pk(0, 5, 15, 30, 0, 2'b00));

    // timeout in EDIT_HR
    hour_i = 5'd7; min_i = 6'd8; sec_i = 6'd9;
    step(1, 0, 0, "t_cap", pk(0, 7, 8, 9, 1, 2'b01));
    for (int j = 1; j < 20; j++)
      step(0, 0, 0, $sformatf("t_hold%0d", j), pk(0, 7, 8, 9, 1, 2'b01));
    step(0, 0, 0, "t_abort", pk(0, 7, 8, 9, 0, 2'b00));
    step(0, 0, 0, "t_after", pk(0, 7, 8, 9, 0, 2'b00));

    // reset during second LOAD cycle, with mode held through release
    hour_i = 5'd4; min_i = 6'd5; sec_i = 6'd6;
    step(1, 0, 0, "l_hr",  pk(0, 4, 5, 6, 1, 2'b01));
    step(0, 0, 0, "l_gap", pk(0, 4, 5, 6, 1, 2'b01));
    step(1, 0, 0, "l_mn",  pk(0, 4, 5, 6, 1, 2'b10));
    step(0, 0, 0, "l_gap", pk(0, 4, 5, 6, 1, 2'b10));
    step(1, 0, 0, "l_sc",  pk(0, 4, 5, 6, 1, 2'b11));
    step(0, 0, 0, "l_gap", pk(0, 4, 5, 6, 1, 2'b11));
    step(1, 0, 0, "l_ld1", pk(1, 4, 5, 6, 0, 2'b00));
    step(0, 0, 0, "l_ld2", pk(1, 4, 5, 6, 0, 2'b00));
    mode_i  = 1'b1;
    reset_i = 1'b1;
    #1;
    exp_q.push_back(pk(0, 12, 0, 0, 0, 2'b00)); tag_q.push_back("rst_async");
    compare_head();
    tick(); tick();
    reset_i = 1'b0;
    step(1, 0, 0, "held_rst", pk(0, 12, 0, 0, 0, 2'b00));
    step(0, 0, 0, "rel_btn",  pk(0, 12, 0, 0, 0, 2'b00));
    step(1, 0, 0, "re_cap",   pk(0, 4, 5, 6, 1, 2'b01));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
